// File: rtl/adder_tb_pkg.sv
// Shared definitions for the adder checker: FSM state encoding and counter sizing.
package adder_tb_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned N_DEF   = 4;

    // Run-status FSM encoding.
    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter width for an n-bit adder: wide enough to hold 2**(2n+1) with headroom.
    function automatic int unsigned cnt_width(input int unsigned n);
        return 2 * n + 2;
    endfunction

endpackage

// File: rtl/adder_ref.sv
// Golden model for the adder under test: {cout,sum} = a + b + cin at n+1 bits.
module adder_ref #(
    parameter int unsigned n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n:0]   exp
);

    localparam int unsigned W = n + 1;

    // Zero-extend each operand so the carry lands in the top bit.
    assign exp = W'(a) + W'(b) + W'(cin);

endmodule

// File: rtl/adder_checker.sv
// Exhaustive-run checker for an n-bit adder: counts vectors and mismatches and
// reports pass/fail. First-fail capture (ff_a/ff_b/ff_cin) is built only when
// ADDER_CHECKER_FIRST_FAIL_EN is defined; otherwise those outputs tie to 0.
module adder_checker
    import adder_tb_pkg::*;
#(
    parameter int unsigned n     = N_DEF,
    parameter int unsigned TOTAL = 2 ** (2 * n + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             valid,
    input  logic [n-1:0]     a,
    input  logic [n-1:0]     b,
    input  logic             cin,
    input  logic [n-1:0]     sum,
    input  logic             cout,
    output logic [2*n+1:0]   vec_count,
    output logic [2*n+1:0]   err_count,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [n-1:0]     ff_a,
    output logic [n-1:0]     ff_b,
    output logic             ff_cin
);

    localparam int unsigned CW = cnt_width(n);
    localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);
    localparam logic [CW-1:0] ERR_SAT = '1;

    state_e          state_q, state_d;
    logic [CW-1:0]   vec_q, vec_d;
    logic [CW-1:0]   err_q, err_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [n:0]      exp_c;
    logic            mismatch_c;

    // Reference sum for the current stimulus.
    adder_ref #(.n(n)) u_ref (
        .a   (a),
        .b   (b),
        .cin (cin),
        .exp (exp_c)
    );

    assign mismatch_c = ({cout, sum} != exp_c);

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state, counter update and registered status flags.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    vec_d   = '0;
                    err_d   = '0;
                end
            end
            RUN: begin
                if (valid) begin
                    vec_d = vec_q + CW'(1);
                    if (mismatch_c && (err_q != ERR_SAT)) begin
                        err_d = err_q + CW'(1);
                    end
                    if (vec_d == TOTAL_C) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
        pass_d = (state_d == DONE) && (err_d == '0);
    end

    assign vec_count = vec_q;
    assign err_count = err_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;

`ifdef ADDER_CHECKER_FIRST_FAIL_EN
    logic [n-1:0] ff_a_q;
    logic [n-1:0] ff_b_q;
    logic         ff_cin_q;
    logic         ff_clear_c;
    logic         ff_capture_c;

    // Clear on an accepted start; capture only while no error has been counted yet.
    always_comb begin
        ff_clear_c   = 1'b0;
        ff_capture_c = 1'b0;
        if ((state_q != RUN) && start) begin
            ff_clear_c = 1'b1;
        end
        if ((state_q == RUN) && valid && mismatch_c && (err_q == '0)) begin
            ff_capture_c = 1'b1;
        end
    end

    // First-failing stimulus registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_a_q   <= '0;
            ff_b_q   <= '0;
            ff_cin_q <= 1'b0;
        end else if (ff_clear_c) begin
            ff_a_q   <= '0;
            ff_b_q   <= '0;
            ff_cin_q <= 1'b0;
        end else if (ff_capture_c) begin
            ff_a_q   <= a;
            ff_b_q   <= b;
            ff_cin_q <= cin;
        end
    end

    assign ff_a   = ff_a_q;
    assign ff_b   = ff_b_q;
    assign ff_cin = ff_cin_q;
`else
    assign ff_a   = '0;
    assign ff_b   = '0;
    assign ff_cin = 1'b0;
`endif

endmodule

// File: tb/tb_adder_checker.sv
// Randomized self-checking bench for adder_checker (n=4) with an event-level model.
module tb_adder_checker;

    localparam int N     = 4;
    localparam int TOTAL = 512;
    localparam int CW    = 10;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          valid = 1'b0;
    logic [N-1:0]  a     = '0;
    logic [N-1:0]  b     = '0;
    logic          cin   = 1'b0;
    logic [N-1:0]  sum   = '0;
    logic          cout  = 1'b0;
    logic [CW-1:0] vec_count;
    logic [CW-1:0] err_count;
    logic          busy;
    logic          done;
    logic          pass;
    logic [N-1:0]  ff_a;
    logic [N-1:0]  ff_b;
    logic          ff_cin;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model state: run in progress, run finished, counts and first failure.
    bit m_run  = 1'b0;
    bit m_fin  = 1'b0;
    bit m_have = 1'b0;
    int m_vec  = 0;
    int m_err  = 0;
    int m_ffa  = 0;
    int m_ffb  = 0;
    int m_ffc  = 0;
    int m_truth;

    adder_checker #(.n(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .valid     (valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .vec_count (vec_count),
        .err_count (err_count),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .ff_a      (ff_a),
        .ff_b      (ff_b),
        .ff_cin    (ff_cin)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: reacts to each accepted start / valid vector.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_fin = 0; m_have = 0;
            m_vec = 0; m_err = 0; m_ffa = 0; m_ffb = 0; m_ffc = 0;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_fin = 0; m_have = 0;
                m_vec = 0; m_err = 0; m_ffa = 0; m_ffb = 0; m_ffc = 0;
            end
        end else if (valid) begin
            m_truth = int'(a) + int'(b) + int'(cin);
            m_vec++;
            if (int'({cout, sum}) != m_truth) begin
                if (m_err < (1 << CW) - 1) m_err++;
                if (!m_have) begin
                    m_have = 1;
`ifdef ADDER_CHECKER_FIRST_FAIL_EN
                    m_ffa = int'(a); m_ffb = int'(b); m_ffc = int'(cin);
`endif
                end
            end
            if (m_vec == TOTAL) begin
                m_run = 0;
                m_fin = 1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("vec_count", int'(vec_count), m_vec);
            check("err_count", int'(err_count), m_err);
            check("busy", int'(busy), int'(m_run));
            check("done", int'(done), int'(m_fin));
            check("pass", int'(pass), int'(m_fin && (m_err == 0)));
            check("ff_a", int'(ff_a), m_ffa);
            check("ff_b", int'(ff_b), m_ffb);
            check("ff_cin", int'(ff_cin), m_ffc);
        end
    end

    // Faulty-adder behaviours applied to a correct result.
    function automatic logic [4:0] fault(input int mode, input int idx, input logic [4:0] r);
        logic [4:0] f;
        f = r;
        case (mode)
            1: f[0] = 1'b0;
            2: if (idx == TOTAL - 1) f[0] = ~f[0];
            3: if ($urandom_range(0, 7) == 0) f = f ^ 5'($urandom_range(1, 31));
            default: ;
        endcase
        return f;
    endfunction

    task automatic start_run();
        start = 1'b1;
        valid = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Vector index i maps to a=i[3:0], b=i[7:4], cin=i[8]. pct<0 toggles valid (0 first).
    task automatic drive_vectors(input int from_idx, input int mode, input int pct,
                                 input bit rnd_start, input int stop_at,
                                 output int idx_out, output int cyc);
        int idx;
        bit v;
        logic [4:0] r;
        idx = from_idx;
        cyc = 0;
        while (idx < TOTAL && idx != stop_at && cyc < 20000) begin
            if (pct < 0)        v = cyc[0];
            else if (pct >= 100) v = 1'b1;
            else                 v = ($urandom_range(0, 99) < pct);
            start = rnd_start && ($urandom_range(0, 15) == 0);
            valid = v;
            if (v) begin
                a   = N'(idx);
                b   = N'(idx >> 4);
                cin = 1'(idx >> 8);
                r   = 5'(int'(a) + int'(b) + int'(cin));
                r   = fault(mode, idx, r);
            end else begin
                a   = N'($urandom);
                b   = N'($urandom);
                cin = 1'($urandom);
                r   = 5'($urandom);
            end
            {cout, sum} = r;
            @(posedge clk);
            #1;
            cyc++;
            if (v) idx++;
        end
        valid = 1'b0;
        start = 1'b0;
        idx_out = idx;
        if (cyc >= 20000) check("cycle_budget_vectors", idx, TOTAL);
    endtask

    initial begin
        int idx;
        int cyc;
        int exp_ffa, exp_ffb, exp_ffc;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("reset_vec", int'(vec_count), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_pass", int'(pass), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Correct adder, all vectors back to back.
        start_run();
        check("start_busy", int'(busy), 1);
        drive_vectors(0, 0, 100, 1'b0, -1, idx, cyc);
        check("clean_cycles", cyc, 512);
        check("clean_vec", int'(vec_count), 512);
        check("clean_err", int'(err_count), 0);
        check("clean_done", int'(done), 1);
        check("clean_pass", int'(pass), 1);

        // Sum bit 0 stuck at 0, restarted from DONE.
`ifdef ADDER_CHECKER_FIRST_FAIL_EN
        exp_ffa = 1; exp_ffb = 0; exp_ffc = 0;
`else
        exp_ffa = 0; exp_ffb = 0; exp_ffc = 0;
`endif
        start_run();
        drive_vectors(0, 1, 100, 1'b0, -1, idx, cyc);
        check("stuck_err", int'(err_count), 256);
        check("stuck_done", int'(done), 1);
        check("stuck_pass", int'(pass), 0);
        check("stuck_ff_a", int'(ff_a), exp_ffa);
        check("stuck_ff_b", int'(ff_b), exp_ffb);
        check("stuck_ff_cin", int'(ff_cin), exp_ffc);

        // valid toggling 0/1: 1024 cycles to finish; DONE then ignores valid.
        start_run();
        drive_vectors(0, 0, -1, 1'b0, -1, idx, cyc);
        check("toggle_cycles", cyc, 1024);
        check("toggle_vec", int'(vec_count), 512);
        check("toggle_done", int'(done), 1);
        repeat (5) begin
            valid = 1'b1;
            a = N'($urandom); b = N'($urandom); cin = 1'($urandom);
            {cout, sum} = 5'($urandom);
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        check("done_hold_vec", int'(vec_count), 512);

        // Reset after 100 vectors, then a full rerun.
        start_run();
        drive_vectors(0, 1, 100, 1'b0, 100, idx, cyc);
        check("partial_vec", int'(vec_count), 100);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_vec", int'(vec_count), 0);
        check("midreset_err", int'(err_count), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_ff_a", int'(ff_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        start_run();
        drive_vectors(0, 0, 100, 1'b0, -1, idx, cyc);
        check("rerun_vec", int'(vec_count), 512);
        check("rerun_pass", int'(pass), 1);

        // Mismatch only on the final vector.
`ifdef ADDER_CHECKER_FIRST_FAIL_EN
        exp_ffa = 15; exp_ffb = 15; exp_ffc = 1;
`else
        exp_ffa = 0; exp_ffb = 0; exp_ffc = 0;
`endif
        start_run();
        drive_vectors(0, 2, 100, 1'b0, 511, idx, cyc);
        check("last_pre_vec", int'(vec_count), 511);
        check("last_pre_err", int'(err_count), 0);
        check("last_pre_done", int'(done), 0);
        drive_vectors(idx, 2, 100, 1'b0, -1, idx, cyc);
        check("last_err", int'(err_count), 1);
        check("last_done", int'(done), 1);
        check("last_pass", int'(pass), 0);
        check("last_ff_a", int'(ff_a), exp_ffa);
        check("last_ff_b", int'(ff_b), exp_ffb);
        check("last_ff_cin", int'(ff_cin), exp_ffc);

        // Random gaps, random faults, stray start pulses during the run.
        repeat (3) begin
            start_run();
            drive_vectors(0, 3, int'($urandom_range(30, 90)), 1'b1, -1, idx, cyc);
            check("random_done", int'(done), 1);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_checker.md
ADDER_CHECKER -- requirements
Module: adder_checker

Interface
REQ-001 The block SHALL have parameter n, default 4: operand width in bits of the adder under test.
REQ-002 The block SHALL have parameter TOTAL, default 2**(2*n+1): number of vectors in one exhaustive run.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle pulse that begins a run.
REQ-006 The block SHALL have port valid, input, 1 bit: stimulus and DUT result are stable this cycle.
REQ-007 The block SHALL have ports a and b, input, n bits each, and cin, input, 1 bit: stimulus applied to the DUT.
REQ-008 The block SHALL have ports sum, input, n bits, and cout, input, 1 bit: DUT result.
REQ-009 The block SHALL have ports vec_count and err_count, output, 2n+2 bits each: vectors checked and mismatches found.
REQ-010 The block SHALL have ports busy, done and pass, output, 1 bit each: run status.
REQ-011 The block SHALL have ports ff_a and ff_b, output, n bits each, and ff_cin, output, 1 bit: first failing stimulus.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE, start=1 SHALL clear vec_count, err_count and the first-fail registers, and move to RUN on the same edge.
REQ-014 In RUN, each edge with valid=1 SHALL compare {cout,sum} against a+b+cin computed at n+1 bits and increment vec_count by 1.
REQ-015 A mismatch SHALL increment err_count; err_count SHALL saturate at all-ones and never wrap.
REQ-016 Counter updates SHALL be visible one cycle after the sampling edge; there is no other pipeline latency.
REQ-017 In RUN, an edge with valid=0 SHALL change no counter.
REQ-018 The edge on which vec_count reaches TOTAL SHALL also move the FSM to DONE.
REQ-019 In DONE, valid SHALL be ignored and counters held; start=1 SHALL restart exactly as REQ-013.
REQ-020 start asserted during RUN SHALL be ignored.
REQ-021 busy SHALL be 1 only in RUN, and done SHALL be 1 only in DONE.
REQ-022 pass SHALL be 1 only in DONE with err_count==0, and 0 in every other case.
REQ-023 The first-fail registers SHALL capture a, b and cin only on the first mismatch of a run; later mismatches SHALL leave them unchanged.
REQ-024 A mismatch and the final vector on the same edge SHALL count the error, capture the first fail if applicable, and enter DONE.

Reset
REQ-025 When rst_n=0, the block SHALL asynchronously force state IDLE and set vec_count, err_count, busy, done, pass, ff_a, ff_b and ff_cin to 0.
REQ-026 Assertion of reset mid-run SHALL abandon the run; no partial result SHALL be retained.
REQ-027 Reset deassertion SHALL be synchronous to clk; the first start accepted is on the first edge after deassertion.

Configuration
REQ-028 With macro ADDER_CHECKER_FIRST_FAIL_EN defined, the first-fail capture registers SHALL be built and behave per REQ-023.
REQ-029 With ADDER_CHECKER_FIRST_FAIL_EN undefined, ff_a, ff_b and ff_cin SHALL be constant 0, no capture registers SHALL exist, and all other behaviour SHALL be unchanged.

Structure
REQ-030 A shared package adder_tb_pkg SHALL hold the FSM state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the counter-width constant.
REQ-031 The golden model SHALL be one combinational sub-module, adder_ref, with inputs a, b, cin and output exp[n:0], instantiated once.

Verification
REQ-032 Reset, start, then a correct DUT with all 512 vectors at n=4 SHALL give done=1, pass=1, vec_count=512, err_count=0.
REQ-033 A DUT with sum bit 0 stuck at 0 SHALL give err_count=256 and ff_a=1, ff_b=0, ff_cin=0 at DONE.
REQ-034 valid toggled 1/0 every cycle SHALL reach DONE after 1024 cycles with vec_count=512.
REQ-035 rst_n=0 after 100 vectors SHALL clear all outputs at once; a following start and full run SHALL give vec_count=512.
REQ-036 A mismatch on vector 512 only SHALL give err_count=1 and done=1 on the same update, with ff_a=15, ff_b=15, ff_cin=1.
REQ-037 A build without ADDER_CHECKER_FIRST_FAIL_EN rerunning REQ-033 SHALL give err_count=256 and ff_a=ff_b=ff_cin=0.
